lifo_fifo_buffer: RTL and testbench
===================================

# lifo_fifo_buffer

Parametrised storage buffer that runs as a LIFO stack or a FIFO queue, selected by a mode input. It succeeds the fixed push/pop stack and adds:
- queue mode with wrap-around pointers
- simultaneous push/pop
- occupancy count and almost-full/almost-empty levels
- sticky overflow/underflow error flags

It sits between a producer and a consumer in the lab datapath designs and exposes the same push/pop/full/empty handshake as the stack.

## Interface
- DEPTH, 8, number of entries; any value ≥ 2.
- WIDTH, 4, data bits per entry.
- AF_LEVEL, DEPTH-2, almost_full asserts when count ≥ AF_LEVEL.
- AE_LEVEL, 2, almost_empty asserts when count ≤ AE_LEVEL.
- CW, $clog2(DEPTH+1), count width (derived; do not override).

Ports:
- clk  input  1  rising-edge clock.
- rstN  input  1  asynchronous, active-low reset.
- mode  input  1  0 = LIFO, 1 = FIFO.
- push  input  1  write request.
- pop  input  1  read request.
- clr_err  input  1  clears overflow and underflow.
- data_in  input  WIDTH  write data.
- data_out  output  WIDTH  last popped value, registered.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- almost_full  output  1  count ≥ AF_LEVEL.
- almost_empty  output  1  count ≤ AE_LEVEL.
- count  output  CW  current occupancy.
- overflow  output  1  sticky: push was rejected.
- underflow  output  1  sticky: pop was rejected.
- mode_q  output  1  active mode.

## Operation
- Reset (rstN low, asynchronous) gives:
  - count = 0, data_out = 0, overflow = 0, underflow = 0, mode_q = 0
  - empty = 1, full = 0, almost_empty = 1, almost_full = 0 (with default levels)
  - pointers = 0
- Storage contents are not reset.
- Mode latch: mode_q <= mode only on an edge where count == 0 and no push is accepted. Otherwise mode is ignored, so the mode never changes while data is held.
- LIFO (mode_q = 0):
  - push writes mem[count] and increments count.
  - pop loads mem[count-1] into data_out and decrements count.
- FIFO (mode_q = 1):
  - push writes mem[wr_ptr], then wr_ptr advances.
  - pop loads mem[rd_ptr] into data_out, then rd_ptr advances.
  - Both pointers wrap from DEPTH-1 to 0. count tracks occupancy.
- Simultaneous push and pop, not empty: both are accepted and count is unchanged.
  - LIFO: data_out <= old top; the top entry is replaced by data_in.
  - FIFO: data_out <= head; data_in is written at the tail. This also applies when full.
- Simultaneous push and pop, empty: the push is accepted and the pop is rejected. count becomes 1 and underflow is set.
- Push while full without pop: rejected. Storage, count and pointers are unchanged; overflow is set.
- Pop while empty: rejected. data_out holds its value; underflow is set.
- overflow/underflow are sticky until clr_err or reset.
  - clr_err clears them on the next edge.
  - If a new error occurs in the same cycle as clr_err, the flag stays set (the set wins).
- FIFO pointers reset to 0 whenever a mode change is latched.

## Timing
- All outputs are registered except full, empty, almost_full and almost_empty, which decode count combinationally.
- Read latency is 1 cycle: data_out is valid after the edge that accepts the pop and holds until the next accepted pop.
- Push-to-visible: an entry pushed at edge N can be popped at edge N+1.
- Throughput: one push and one pop per cycle, sustained.
- count, the flags and the error bits all update on the same edge as the operation.
- Reset mid-operation: outputs reach their reset values immediately, without waiting for clk. An in-flight pop does not update data_out.

## Test plan
All scenarios use DEPTH = 8 and WIDTH = 4.
- LIFO fill/drain:
  - Push 1..8 → full = 1, count = 8, almost_full from count 6.
  - A 9th push of 9 → overflow = 1, count stays 8.
  - Pop ×9 → data_out 8,7,…,1; the 9th pop sets underflow = 1 with data_out holding 1.
- FIFO wrap:
  - Set mode = 1 while empty; push 1..8, pop 4 → data_out 1,2,3,4.
  - Push 9..12, then pop 8 → data_out 5..12, confirming pointer wrap; empty = 1 at the end.
- Simultaneous push/pop:
  - LIFO with 3 entries (1,2,3): push 7 and pop together → data_out = 3, count = 3; next pop → 7.
  - FIFO full (1..8): push 9 and pop together → data_out = 1, full stays 1, no overflow.
- Mode lock: LIFO holding 2 entries, drive mode = 1 → mode_q stays 0 until the buffer drains, then becomes 1.
- Errors:
  - Underflow set; assert clr_err 1 cycle → underflow = 0.
  - clr_err together with a pop on empty → underflow remains 1.
- Async reset: assert rstN = 0 mid-clock with count = 5 → count = 0, empty = 1, data_out = 0 immediately, before the next edge.

Source files
------------

// File: rtl/lifo_fifo_buffer.sv
// Storage buffer that runs as a LIFO stack or a FIFO queue selected by mode.
// Supports simultaneous push/pop, occupancy levels and sticky error flags.
module lifo_fifo_buffer #(
    parameter int unsigned DEPTH    = 8,
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned AF_LEVEL = DEPTH - 2,
    parameter int unsigned AE_LEVEL = 2,
    parameter int unsigned CW       = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rstN,
    input  logic             mode,
    input  logic             push,
    input  logic             pop,
    input  logic             clr_err,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out,
    output logic             full,
    output logic             empty,
    output logic             almost_full,
    output logic             almost_empty,
    output logic [CW-1:0]    count,
    output logic             overflow,
    output logic             underflow,
    output logic             mode_q
);

    localparam int unsigned PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];

    logic [CW-1:0]    count_q, count_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [WIDTH-1:0] data_out_q, data_out_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;
    logic             act_mode_q, act_mode_d;

    logic             is_empty, is_full, push_ok, pop_ok, wr_en;
    logic [PW-1:0]    wr_addr, rd_addr, top_addr;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Acceptance, addressing and next-state for every register
    always_comb begin
        count_d     = count_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        data_out_d  = data_out_q;
        act_mode_d  = act_mode_q;
        wr_en       = 1'b0;

        is_empty = (count_q == '0);
        is_full  = (count_q == CW'(DEPTH));
        // A pop frees a slot in the same edge, so a full buffer still takes push+pop
        push_ok  = push && (!is_full || pop);
        pop_ok   = pop && !is_empty;
        top_addr = PW'(count_q - CW'(1));

        if (act_mode_q) begin
            wr_addr = wr_ptr_q;
            rd_addr = rd_ptr_q;
        end else begin
            wr_addr = (push_ok && pop_ok) ? top_addr : PW'(count_q);
            rd_addr = top_addr;
        end

        wr_en = push_ok;
        if (pop_ok) begin
            data_out_d = mem_q[rd_addr];
        end

        if (act_mode_q && push_ok) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end
        if (act_mode_q && pop_ok) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end

        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        // A new error in the clearing cycle wins over clr_err
        overflow_d  = (overflow_q && !clr_err) || (push && !push_ok);
        underflow_d = (underflow_q && !clr_err) || (pop && !pop_ok);

        // Mode only moves while nothing is stored and nothing arrives
        if (is_empty && !push_ok) begin
            act_mode_d = mode;
            if (mode != act_mode_q) begin
                rd_ptr_d = '0;
                wr_ptr_d = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            count_q     <= '0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            data_out_q  <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            act_mode_q  <= 1'b0;
        end else begin
            count_q     <= count_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            data_out_q  <= data_out_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
            act_mode_q  <= act_mode_d;
        end
    end

    // Storage array has no reset
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= data_in;
        end
    end

    assign data_out     = data_out_q;
    assign count        = count_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;
    assign mode_q       = act_mode_q;
    assign full         = (count_q == CW'(DEPTH));
    assign empty        = (count_q == '0);
    assign almost_full  = (count_q >= CW'(AF_LEVEL));
    assign almost_empty = (count_q <= CW'(AE_LEVEL));

endmodule

// File: tb/tb_lifo_fifo_buffer.sv
// Scoreboard bench for lifo_fifo_buffer: stimulus queues expectations per cycle,
// a monitor compares them shortly after each rising edge.
module tb_lifo_fifo_buffer;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned WIDTH = 4;
    localparam int unsigned CW    = 4;

    localparam int S_DOUT  = 0;
    localparam int S_CNT   = 1;
    localparam int S_FULL  = 2;
    localparam int S_EMPTY = 3;
    localparam int S_AF    = 4;
    localparam int S_AE    = 5;
    localparam int S_OVF   = 6;
    localparam int S_UNF   = 7;
    localparam int S_MODE  = 8;

    logic             clk;
    logic             rstN;
    logic             mode;
    logic             push;
    logic             pop;
    logic             clr_err;
    logic [WIDTH-1:0] data_in;
    logic [WIDTH-1:0] data_out;
    logic             full;
    logic             empty;
    logic             almost_full;
    logic             almost_empty;
    logic [CW-1:0]    count;
    logic             overflow;
    logic             underflow;
    logic             mode_q;

    lifo_fifo_buffer #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk         (clk),
        .rstN        (rstN),
        .mode        (mode),
        .push        (push),
        .pop         (pop),
        .clr_err     (clr_err),
        .data_in     (data_in),
        .data_out    (data_out),
        .full        (full),
        .empty       (empty),
        .almost_full (almost_full),
        .almost_empty(almost_empty),
        .count       (count),
        .overflow    (overflow),
        .underflow   (underflow),
        .mode_q      (mode_q)
    );

    typedef struct {
        int    cyc;
        int    sel;
        int    val;
        string name;
    } exp_t;

    exp_t sb[$];
    int   n_vec   = 0;
    int   n_err   = 0;
    int   mon_cyc = 0;
    logic cur_mode = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] actual(input int sel);
        case (sel)
            S_DOUT:  return 32'(data_out);
            S_CNT:   return 32'(count);
            S_FULL:  return 32'(full);
            S_EMPTY: return 32'(empty);
            S_AF:    return 32'(almost_full);
            S_AE:    return 32'(almost_empty);
            S_OVF:   return 32'(overflow);
            S_UNF:   return 32'(underflow);
            default: return 32'(mode_q);
        endcase
    endfunction

    task automatic sb_exp(input int sel, input int val, input string name);
        exp_t e;
        e.cyc  = mon_cyc + 1;
        e.sel  = sel;
        e.val  = val;
        e.name = name;
        sb.push_back(e);
    endtask

    task automatic chk_now(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic op(input logic p, input logic q, input logic [WIDTH-1:0] d, input logic c);
        @(negedge clk);
        push    = p;
        pop     = q;
        data_in = d;
        clr_err = c;
        mode    = cur_mode;
    endtask

    // Monitor: results settle just after each rising edge
    initial begin
        exp_t        e;
        logic [31:0] a;
        forever begin
            @(posedge clk);
            #1;
            mon_cyc++;
            while (sb.size() > 0 && sb[0].cyc <= mon_cyc) begin
                e = sb.pop_front();
                n_vec++;
                if (e.cyc < mon_cyc) begin
                    n_err++;
                    $display("FAIL %s: check for cycle %0d not taken (now %0d)", e.name, e.cyc, mon_cyc);
                end else begin
                    a = actual(e.sel);
                    if (a !== 32'(e.val)) begin
                        n_err++;
                        $display("FAIL %s @cyc %0d: got %0d, expected %0d", e.name, mon_cyc, a, e.val);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        rstN = 1'b0; mode = 1'b0; push = 1'b0; pop = 1'b0; clr_err = 1'b0; data_in = '0;
        #2;
        chk_now("rst_count", 32'(count), 0);
        chk_now("rst_dout", 32'(data_out), 0);
        chk_now("rst_empty", 32'(empty), 1);
        chk_now("rst_full", 32'(full), 0);
        chk_now("rst_ae", 32'(almost_empty), 1);
        chk_now("rst_af", 32'(almost_full), 0);
        chk_now("rst_ovf", 32'(overflow), 0);
        chk_now("rst_unf", 32'(underflow), 0);
        chk_now("rst_mode", 32'(mode_q), 0);
        @(negedge clk);
        rstN = 1'b1;

        // LIFO fill, overflow, drain, underflow
        for (int i = 1; i <= 8; i++) begin
            op(1, 0, 4'(i), 0);
            sb_exp(S_CNT, i, "lifo_fill_count");
            sb_exp(S_AF, (i >= 6) ? 1 : 0, "lifo_fill_af");
            sb_exp(S_AE, (i <= 2) ? 1 : 0, "lifo_fill_ae");
            sb_exp(S_FULL, (i == 8) ? 1 : 0, "lifo_fill_full");
        end
        op(1, 0, 4'd9, 0);
        sb_exp(S_OVF, 1, "lifo_overflow");
        sb_exp(S_CNT, 8, "lifo_overflow_count");
        for (int i = 8; i >= 1; i--) begin
            op(0, 1, 4'd0, 0);
            sb_exp(S_DOUT, i, "lifo_drain_dout");
            sb_exp(S_CNT, i - 1, "lifo_drain_count");
        end
        op(0, 1, 4'd0, 0);
        sb_exp(S_UNF, 1, "lifo_underflow");
        sb_exp(S_DOUT, 1, "lifo_underflow_hold");
        sb_exp(S_EMPTY, 1, "lifo_empty");
        op(0, 0, 4'd0, 1);
        sb_exp(S_UNF, 0, "clr_unf");
        sb_exp(S_OVF, 0, "clr_ovf");
        op(0, 1, 4'd0, 1);
        sb_exp(S_UNF, 1, "clr_vs_new_unf");
        op(0, 0, 4'd0, 1);
        sb_exp(S_UNF, 0, "clr_again");

        // FIFO wrap
        cur_mode = 1'b1;
        op(0, 0, 4'd0, 0);
        sb_exp(S_MODE, 1, "fifo_mode_latch");
        for (int i = 1; i <= 8; i++) op(1, 0, 4'(i), 0);
        for (int i = 1; i <= 4; i++) begin
            op(0, 1, 4'd0, 0);
            sb_exp(S_DOUT, i, "fifo_pop_a");
        end
        for (int i = 9; i <= 12; i++) op(1, 0, 4'(i), 0);
        sb_exp(S_FULL, 1, "fifo_full_wrap");
        for (int i = 5; i <= 12; i++) begin
            op(0, 1, 4'd0, 0);
            sb_exp(S_DOUT, i, "fifo_pop_wrap");
        end
        sb_exp(S_EMPTY, 1, "fifo_empty_end");

        // FIFO full simultaneous push/pop
        for (int i = 1; i <= 8; i++) op(1, 0, 4'(i), 0);
        op(1, 1, 4'd9, 0);
        sb_exp(S_DOUT, 1, "fifo_full_pp_dout");
        sb_exp(S_FULL, 1, "fifo_full_pp_full");
        sb_exp(S_OVF, 0, "fifo_full_pp_ovf");
        sb_exp(S_CNT, 8, "fifo_full_pp_count");
        for (int i = 2; i <= 9; i++) begin
            op(0, 1, 4'd0, 0);
            sb_exp(S_DOUT, i, "fifo_full_pp_drain");
        end

        // Push+pop on empty: push wins, pop rejected
        op(1, 1, 4'd5, 0);
        sb_exp(S_CNT, 1, "empty_pp_count");
        sb_exp(S_UNF, 1, "empty_pp_unf");
        sb_exp(S_DOUT, 9, "empty_pp_dout_hold");
        op(0, 1, 4'd0, 0);
        sb_exp(S_DOUT, 5, "empty_pp_pop");
        op(0, 0, 4'd0, 1);

        // LIFO simultaneous push/pop
        cur_mode = 1'b0;
        op(0, 0, 4'd0, 0);
        sb_exp(S_MODE, 0, "lifo_mode_latch");
        for (int i = 1; i <= 3; i++) op(1, 0, 4'(i), 0);
        op(1, 1, 4'd7, 0);
        sb_exp(S_DOUT, 3, "lifo_pp_dout");
        sb_exp(S_CNT, 3, "lifo_pp_count");
        op(0, 1, 4'd0, 0);
        sb_exp(S_DOUT, 7, "lifo_pp_new_top");
        op(0, 1, 4'd0, 0);
        sb_exp(S_DOUT, 2, "lifo_pp_next");
        op(0, 1, 4'd0, 0);
        sb_exp(S_DOUT, 1, "lifo_pp_last");
        sb_exp(S_EMPTY, 1, "lifo_pp_empty");

        // Mode lock while holding data
        op(1, 0, 4'd1, 0);
        op(1, 0, 4'd2, 0);
        cur_mode = 1'b1;
        op(0, 0, 4'd0, 0);
        sb_exp(S_MODE, 0, "lock_hold_idle");
        op(0, 1, 4'd0, 0);
        sb_exp(S_MODE, 0, "lock_hold_pop1");
        sb_exp(S_DOUT, 2, "lock_pop1");
        op(0, 1, 4'd0, 0);
        sb_exp(S_MODE, 0, "lock_hold_pop2");
        sb_exp(S_DOUT, 1, "lock_pop2");
        op(0, 0, 4'd0, 0);
        sb_exp(S_MODE, 1, "lock_release");

        // Async reset mid-cycle with five entries held
        op(0, 1, 4'd0, 0);
        sb_exp(S_UNF, 1, "pre_reset_unf");
        for (int i = 1; i <= 5; i++) op(1, 0, 4'(i + 2), 0);
        op(0, 1, 4'd0, 0);
        sb_exp(S_DOUT, 3, "pre_reset_dout");
        op(1, 0, 4'd8, 0);
        sb_exp(S_CNT, 5, "pre_reset_count");
        @(posedge clk);
        #2;
        rstN = 1'b0;
        #1;
        chk_now("areset_count", 32'(count), 0);
        chk_now("areset_empty", 32'(empty), 1);
        chk_now("areset_dout", 32'(data_out), 0);
        chk_now("areset_unf", 32'(underflow), 0);
        chk_now("areset_mode", 32'(mode_q), 0);
        cur_mode = 1'b0;
        push = 1'b0; pop = 1'b0; mode = 1'b0;
        @(negedge clk);
        rstN = 1'b1;
        op(0, 0, 4'd0, 0);
        sb_exp(S_CNT, 0, "post_reset_count");

        repeat (3) @(posedge clk);
        #2;
        if (sb.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL scoreboard_drain: %0d checks left, expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
